// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared types and constants for the PWM duty ramp controller.
package pwm_ctrl_pkg;
    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] STEP_RESET = 8'd1;
    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_COMMIT} state_t;
    // The step register sits one address above the last channel target.
    function automatic logic is_step_addr(input int unsigned addr, input int unsigned nch);
        return addr == nch;
    endfunction
endpackage

// File: rtl/pwm_slew.sv
// pwm_slew: moves a duty toward its target by at most step; step 0 means jump.
module pwm_slew
    import pwm_ctrl_pkg::*;
(
    input  logic [DUTY_W-1:0] i_cur,
    input  logic [DUTY_W-1:0] i_tgt,
    input  logic [DUTY_W-1:0] i_step,
    output logic [DUTY_W-1:0] o_next
);
    logic              w_up;
    logic [DUTY_W-1:0] w_diff;
    assign w_up   = i_tgt > i_cur;
    assign w_diff = w_up ? i_tgt - i_cur : i_cur - i_tgt;
    // A move is applied only when the gap exceeds step, so it cannot wrap.
    assign o_next = (i_step == '0 || w_diff <= i_step) ? i_tgt
                  : w_up ? i_cur + i_step : i_cur - i_step;
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: per-frame slewing of channel duties toward host targets,
// committed to all outputs atomically at the end of each sweep.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int PERIOD = 256,
    parameter int AW     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DUTY_W-1:0]     wr_data,
    output logic [DUTY_W*NCH-1:0] duty_out,
    output logic                  frame_tick,
    output logic                  busy,
    output logic                  settled
);
    localparam int CW = $clog2(PERIOD);
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic              r_tick, r_settled, w_last, w_eq, w_wrap;
    logic [DUTY_W-1:0] r_tgt [NCH];
    logic [DUTY_W-1:0] r_cur [NCH];
    logic [DUTY_W-1:0] r_duty [NCH];
    logic [DUTY_W-1:0] r_step, w_slew;
    assign w_last = r_idx == IW'(NCH - 1);
    assign w_wrap = r_cnt == CW'(PERIOD - 1);
    pwm_slew u_slew (
        .i_cur (r_cur[r_idx]),
        .i_tgt (r_tgt[r_idx]),
        .i_step(r_step),
        .o_next(w_slew)
    );
    always_comb begin
        w_next = (r_state == ST_IDLE)  ? (r_tick ? ST_SWEEP : ST_IDLE)
               : (r_state == ST_SWEEP) ? (w_last ? ST_COMMIT : ST_SWEEP)
               : ST_IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_idx  <= '0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            r_tick <= w_wrap;
            r_idx  <= (r_state == ST_SWEEP && !w_last) ? r_idx + 1'b1 : '0;
        end
    end
    always_comb begin
        w_eq = 1'b1;
        for (int i = 0; i < NCH; i++) w_eq = w_eq & (r_duty[i] == r_tgt[i]);
    end
    // Host writes touch only targets and step; cur/duty move solely via the sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_tgt[i]  <= '0;
                r_cur[i]  <= '0;
                r_duty[i] <= '0;
            end
            r_step    <= STEP_RESET;
            r_settled <= 1'b1;
        end else begin
            if (wr_en) begin
                for (int i = 0; i < NCH; i++) if (wr_addr == AW'(i)) r_tgt[i] <= wr_data;
                if (is_step_addr(32'(wr_addr), NCH)) r_step <= wr_data;
            end
            if (r_state == ST_SWEEP) r_cur[r_idx] <= w_slew;
            if (r_state == ST_COMMIT) r_duty <= r_cur;
            r_settled <= w_eq;
        end
    end
    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign duty_out[DUTY_W*g +: DUTY_W] = r_duty[g];
    end
    assign frame_tick = r_tick;
    assign busy       = r_state != ST_IDLE;
    assign settled    = r_settled;
endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Per-channel duty-cycle controller that feeds the `val` inputs of NCH 8-bit PWM generators.
- Host writes a target duty per channel plus one global ramp step.
- Once per PWM frame, a sequencer walks the channels and slews each current duty toward its target by at most the step.
- All outputs then update atomically, so motor/LED drives never see a mid-frame duty change or a jump larger than the step.

Parameters:
- NCH, 4, number of PWM channels (1..16).
- PERIOD, 256, frame length in clk cycles; matches the 8-bit PWM wrap; must be >= NCH+3.
- AW, 5, write-address width; must satisfy 2^AW > NCH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe, one cycle per write; always accepted, no backpressure.
- wr_addr  in  AW  0..NCH-1 selects a channel target; NCH selects the step register; larger values are ignored.
- wr_data  in  8  target duty or step value.
- duty_out  out  8*NCH  committed duty per channel, channel i in bits [8i+7:8i]; drives PWM `val`.
- frame_tick  out  1  one-cycle pulse when the frame counter wraps to 0.
- busy  out  1  high while the sequencer is in SWEEP or COMMIT.
- settled  out  1  high when every committed duty equals its target.

Behaviour:
- **Reset values:** duty_out=0; all targets=0; all working duties=0; step=1; frame counter=0; frame_tick=0; busy=0; settled=1; FSM=IDLE.
- **Reset mid-operation:** a reset in any state aborts the sweep with no commit; the values above appear on the next edge.
- **Frame counter:** counts 0..PERIOD-1 and wraps. frame_tick is registered and is high in the cycle after the counter holds PERIOD-1, i.e. coincident with count 0.
- **FSM states:** IDLE, SWEEP, COMMIT.
  - IDLE -> SWEEP on the edge where frame_tick=1; index=0.
  - SWEEP, one channel per cycle: cur[idx] <= slew(cur[idx], tgt[idx], step); index increments. After idx=NCH-1 -> COMMIT.
  - COMMIT, one cycle: duty_out <= all cur. -> IDLE.
  - busy=1 in SWEEP and COMMIT.
- **Latency:** with frame_tick high in cycle T, SWEEP occupies T+1..T+NCH, COMMIT is T+NCH+1, and new duty_out is visible at T+NCH+2.
- **Slew arithmetic:** unsigned 8-bit compare. Let d = |tgt-cur|.
  - If step==0 or d<=step: cur=tgt.
  - Else: cur=cur+step if tgt>cur, otherwise cur-step.
  - No overflow is possible because a move is applied only when d>step.
- **Write timing:**
  - Writes take effect on the next edge.
  - A write to tgt[i] in the same cycle that SWEEP processes channel i: the sweep uses the old target; the new target applies from the next frame.
  - A step write during SWEEP applies only from the next channel processed.
- **Writes and settled:** writes never modify cur or duty_out directly. A target write that leaves duty_out unchanged still takes effect normally.
- **settled:** registered; recomputed every cycle as the AND over channels of (duty_out[i]==tgt[i]).
- **Boundary values:** targets 0 and 255 pass through unchanged; the PWM block handles full-off/full-on.
- **Step 255:** step=255 behaves as an immediate jump.

Decomposition:
- Package pwm_ctrl_pkg holds:
  - FSM state enum (IDLE/SWEEP/COMMIT);
  - DUTY_W=8;
  - STEP_RESET=8'd1;
  - the step-register address convention (addr==NCH).
- Sub-module pwm_slew: a combinational slew function of (cur, tgt, step) -> next; unit-testable in isolation.
- The top level holds the register files, frame counter and FSM.

Test Plan:
- Reset, then idle for 2 frames -> duty_out=0, settled=1, frame_tick period exactly PERIOD, busy width NCH+1 cycles.
- Step=1 (reset value), write tgt[0]=3 -> duty_out[0] goes 1,2,3 on three successive commits; settled=1 after the 3rd commit; other channels stay 0.
- Write step=0x40, tgt[1]=0xFF -> duty_out[1] sequence 0x40,0x80,0xC0,0xFF; then write tgt[1]=0x00 -> 0xBF,0x7F,0x3F,0x00 (clamped, no wrap).
- Step=0 with tgt[2]=0x5A -> duty_out[2]=0x5A at the first commit; new value visible exactly NCH+2 cycles after frame_tick.
- Write tgt[2] in the exact SWEEP cycle for channel 2 -> the current frame commits the old-target slew, the next frame uses the new target; a write to addr NCH+1 changes nothing.
- Assert reset during SWEEP after cur has moved -> no COMMIT occurs, all outputs return to reset values, and the frame counter restarts at 0.
